qpu_ir_buf: RTL
===============

QPU_IR_BUF -- requirements
Module: qpu_ir_buf

Interface
REQ-001 Parameter INSTR_W, default 32, instruction width (matches QPU_INSTR_SIZE).
REQ-002 Parameter PC_W, default 32, PC width (matches QPU_PC_SIZE).
REQ-003 Parameter RFIDX_W, default 5, register index width (matches QPU_RFIDX_WIDTH).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 i_valid  in  1  IFU has an instruction (driven by ifu_o_valid).
REQ-008 i_ready  out  1  buffer accepts an instruction (drives ifu_o_ready).
REQ-009 i_ir  in  INSTR_W  instruction word.
REQ-010 i_pc  in  PC_W  instruction PC.
REQ-011 i_pc_vld  in  1  PC valid flag.
REQ-012 i_rs1idx, i_rs2idx  in  RFIDX_W each  source register indexes.
REQ-013 i_prdt_taken  in  1  branch predicted taken.
REQ-014 o_valid  out  1  head entry valid toward EXU.
REQ-015 o_ready  in  1  EXU accepts head entry.
REQ-016 o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx, o_prdt_taken  out  same widths  head entry fields.
REQ-017 flush_req  in  1  pipeline flush from EXU.
REQ-018 occ  out  2  current occupancy, 0..2.
REQ-019 disp_cnt  out  16  count of instructions handed to EXU.

Function
REQ-020 The block SHALL be a 2-entry FIFO with in-order output; a push occurs when i_valid && i_ready at a rising edge; a pop occurs when o_valid && o_ready at a rising edge.
REQ-021 i_ready SHALL equal (occ != 2) && !flush_req && rst_n, combinationally; it SHALL NOT depend on o_ready (no combinational ready path through the buffer).
REQ-022 o_valid SHALL equal (occ != 0), registered state only.
REQ-023 o_* data fields SHALL present the oldest entry while o_valid=1 and SHALL hold stable until popped; when o_valid=0 their values are don't-care except after reset.
REQ-024 Latency: an instruction pushed at edge N SHALL appear on o_* with o_valid=1 after edge N when the buffer was empty (1-cycle latency); otherwise it SHALL appear after all older entries have been popped.
REQ-025 Simultaneous push and pop at occ=1 SHALL leave occ=1, with the new entry at the head after the edge.
REQ-026 Push at occ=2 is impossible because i_ready=0; pop at occ=0 is impossible because o_valid=0.
REQ-027 Read and write pointers SHALL be 1 bit each and SHALL wrap 1->0.
REQ-028 When flush_req=1 at an edge, occ SHALL become 0 and both pointers SHALL become 0, and any concurrent push SHALL be discarded; flush has priority over push and pop.
REQ-029 A concurrent pop during flush SHALL still count in disp_cnt, since EXU accepted the entry.
REQ-030 disp_cnt SHALL increment by 1 on each pop and SHALL wrap 0xFFFF->0x0000.

Reset
REQ-031 With rst_n=0 at an edge: occ=0, pointers=0, o_valid=0, all o_* data=0, disp_cnt=0.
REQ-032 While rst_n=0, i_ready SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries with no pop counted.
REQ-034 Reset SHALL take priority over flush, push and pop.

Verification
REQ-035 Reset, then i_valid=1 with ir=0x12345678, pc=0x4 and o_ready=0 -> after 1 edge o_valid=1, o_ir=0x12345678, occ=1; after a second push occ=2 and i_ready=0.
REQ-036 Fill with A, B; set o_ready=1 and i_valid=1 with C -> outputs are popped in order A, B, C; occ sequence is 2,1,1,0 once i_valid drops; disp_cnt=3.
REQ-037 occ=2 with flush_req=1 and i_valid=1 for one cycle -> next cycle occ=0, o_valid=0, and the pushed instruction never appears; i_ready=0 during the flush cycle.
REQ-038 Continuous stream with o_ready=1 -> one instruction per cycle, occ stays 1, and disp_cnt wraps from 0xFFFF to 0 after 65536 pops.
REQ-039 Toggle o_ready randomly against a continuous IFU stream -> no loss, no duplication, order preserved, and o_* stable while o_valid && !o_ready.
REQ-040 rst_n=0 asserted at occ=2 -> next cycle all outputs are 0, and i_ready=0 until rst_n=1.

Source files
------------

// File: rtl/qpu_ir_buf.sv
// Purpose : 2-entry in-order instruction buffer between the IFU and the EXU.
// Latency : 1 cycle; a word pushed into an empty buffer is on o_* right after that edge.
// Backpr. : i_ready = not full, no flush, not in reset; it never looks at o_ready.
//
// Ports
//   clk, rst_n                   rising-edge clock, synchronous active-low reset
//   i_valid / i_ready            IFU -> buffer handshake
//   i_ir, i_pc, i_pc_vld,        instruction fields captured on a push
//   i_rs1idx, i_rs2idx,
//   i_prdt_taken
//   o_valid / o_ready            buffer -> EXU handshake
//   o_ir ... o_prdt_taken        fields of the oldest entry
//   flush_req                    empties the buffer; a concurrent pop still counts
//   occ                          number of stored entries, 0..2
//   disp_cnt                     wrapping count of entries accepted by the EXU
module qpu_ir_buf #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               i_valid,
  output logic               i_ready,
  input  logic [INSTR_W-1:0] i_ir,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_pc_vld,
  input  logic [RFIDX_W-1:0] i_rs1idx,
  input  logic [RFIDX_W-1:0] i_rs2idx,
  input  logic               i_prdt_taken,

  output logic               o_valid,
  input  logic               o_ready,
  output logic [INSTR_W-1:0] o_ir,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_pc_vld,
  output logic [RFIDX_W-1:0] o_rs1idx,
  output logic [RFIDX_W-1:0] o_rs2idx,
  output logic               o_prdt_taken,

  input  logic               flush_req,
  output logic [1:0]         occ,
  output logic [15:0]        disp_cnt
);

  // One buffered instruction, kept as a single packed word.
  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc;
    logic               pc_vld;
    logic [RFIDX_W-1:0] rs1idx;
    logic [RFIDX_W-1:0] rs2idx;
    logic               prdt_taken;
  } ir_entry_t;

  ir_entry_t   r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_occ;
  logic [15:0] r_disp_cnt;

  ir_entry_t   w_in_entry;
  ir_entry_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_i_ready;
  logic        w_push;
  logic        w_pop;

  assign w_full  = (r_occ == 2'd2);
  assign w_empty = (r_occ == 2'd0);

  // Ready is derived only from local state and the flush/reset inputs, so the
  // EXU's o_ready never ripples combinationally back to the IFU.
  assign w_i_ready = !w_full && !flush_req && rst_n;
  assign w_push    = i_valid && w_i_ready;
  assign w_pop     = !w_empty && o_ready;

  always_comb begin
    w_in_entry            = '0;
    w_in_entry.ir         = i_ir;
    w_in_entry.pc         = i_pc;
    w_in_entry.pc_vld     = i_pc_vld;
    w_in_entry.rs1idx     = i_rs1idx;
    w_in_entry.rs2idx     = i_rs2idx;
    w_in_entry.prdt_taken = i_prdt_taken;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Storage is cleared too so the head fields read as zero after reset.
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_disp_cnt <= 16'd0;
    end else begin
      // The EXU took the head even if a flush lands on the same edge.
      if (w_pop) begin
        r_disp_cnt <= r_disp_cnt + 16'd1;
      end

      if (flush_req) begin
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
        r_occ  <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= w_in_entry;
          r_wptr        <= ~r_wptr;
        end
        if (w_pop) begin
          r_rptr <= ~r_rptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign w_head = r_mem[r_rptr];

  assign i_ready      = w_i_ready;
  assign o_valid      = !w_empty;
  assign o_ir         = w_head.ir;
  assign o_pc         = w_head.pc;
  assign o_pc_vld     = w_head.pc_vld;
  assign o_rs1idx     = w_head.rs1idx;
  assign o_rs2idx     = w_head.rs2idx;
  assign o_prdt_taken = w_head.prdt_taken;
  assign occ          = r_occ;
  assign disp_cnt     = r_disp_cnt;

  // Occupancy encoding 3 is unreachable; full/empty must never coexist with
  // a push/pop respectively.
  a_occ_range : assert property (@(posedge clk) disable iff (!rst_n) r_occ != 2'd3);
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n) !(w_pop && w_empty));

endmodule
